ddr5_cmd_sequencer: RTL and testbench



---
 rtl/ddr5_cmd_sequencer_pkg.sv | 62 ++++++
 rtl/ddr5_cmd_sequencer_timing_cnt.sv | 42 ++++
 rtl/ddr5_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ddr5_cmd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_cmd_sequencer_pkg.sv
// ============================================================================
// ddr5_pkg : shared DDR5 command/request types and default timing values
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package ddr5_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT0 = 3'd1,
    CMD_ACT1 = 3'd2,
    CMD_RD0  = 3'd3,
    CMD_RD1  = 3'd4,
    CMD_WR0  = 3'd5,
    CMD_WR1  = 3'd6,
    CMD_PRE  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    OPN_READ    = 2'd0,
    OPN_WRITE   = 2'd1,
    OPN_IFETCH  = 2'd2,
    OPN_ILLEGAL = 2'd3
  } opn_e;

  typedef struct packed {
    opn_e        opn;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
  } req_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ACT0     = 4'd1,
    ST_ACT1     = 4'd2,
    ST_WAIT_RCD = 4'd3,
    ST_CAS0     = 4'd4,
    ST_CAS1     = 4'd5,
    ST_WAIT_PRE = 4'd6,
    ST_PRE      = 4'd7,
    ST_WAIT_RP  = 4'd8
  } state_e;

  localparam int DEF_T_RCD   = 39;
  localparam int DEF_T_RAS   = 76;
  localparam int DEF_T_RTP   = 18;
  localparam int DEF_T_CWL   = 38;
  localparam int DEF_T_BURST = 8;
  localparam int DEF_T_WR    = 48;
  localparam int DEF_T_RP    = 39;
  localparam int DEF_CNT_W   = 8;

  function automatic logic is_write(input opn_e opn);
    return (opn == OPN_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr5_cmd_sequencer_timing_cnt.sv
// ============================================================================
// ddr5_timing_cnt : saturating down-counter stepped by the DRAM tick
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ddr5_timing_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ddr5_cmd_sequencer.sv
// ============================================================================
// ddr5_cmd_sequencer : expands one request into ACT0/ACT1/CAS0/CAS1/PRE
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ddr5_cmd_sequencer
  import ddr5_pkg::*;
#(
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_RAS   = DEF_T_RAS,
  parameter int T_RTP   = DEF_T_RTP,
  parameter int T_CWL   = DEF_T_CWL,
  parameter int T_BURST = DEF_T_BURST,
  parameter int T_WR    = DEF_T_WR,
  parameter int T_RP    = DEF_T_RP,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opn,
  input  logic [2:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        req_err
);

  // Counters are loaded one short: a wait state hands over to its issuing
  // state in the non-tick cycle before the tick on which the command goes out.
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] WRR_LD = CNT_W'(T_CWL + T_BURST + T_WR - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic             phase_q, phase_d;
  logic             err_q, err_d;
  logic             tick, transfer, legal, wr;
  logic             ras_load, cas_load, ras_zero, cas_zero;
  logic [CNT_W-1:0] cas_val;

  assign tick      = ~phase_q;
  assign req_ready = (state_q == ST_IDLE);
  assign transfer  = req_valid && req_ready;
  assign legal     = (opn_e'(req_opn) != OPN_ILLEGAL);
  assign wr        = is_write(req_q.opn);
  assign req_err   = err_q;

  always_comb begin
    phase_d = ~phase_q;
    err_d   = transfer && !legal;
    req_d   = req_q;
    if (transfer && legal) begin
      req_d = '{opn: opn_e'(req_opn), bg: req_bg, ba: req_ba, row: req_row, col: req_col};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      phase_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (transfer && legal) state_d = ST_ACT0;
      ST_ACT0:     if (tick) state_d = ST_ACT1;
      ST_ACT1:     if (tick) state_d = ST_WAIT_RCD;
      ST_WAIT_RCD: if (cas_zero) state_d = ST_CAS0;
      ST_CAS0:     if (tick) state_d = ST_CAS1;
      ST_CAS1:     if (tick) state_d = ST_WAIT_PRE;
      ST_WAIT_PRE: if (ras_zero && cas_zero) state_d = ST_PRE;
      ST_PRE:      if (tick) state_d = ST_WAIT_RP;
      ST_WAIT_RP:  if (cas_zero) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_code  = CMD_NOP;
    cmd_bg    = '0;
    cmd_ba    = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    ras_load  = 1'b0;
    cas_load  = 1'b0;
    cas_val   = RCD_LD;
    if (tick) begin
      unique case (state_q)
        ST_ACT0: begin
          cmd_valid = 1'b1;
          cmd_code  = CMD_ACT0;
          cmd_row   = req_q.row;
          ras_load  = 1'b1;
          cas_load  = 1'b1;
          cas_val   = RCD_LD;
        end
        ST_ACT1: begin
          cmd_valid = 1'b1;
          cmd_code  = CMD_ACT1;
          cmd_row   = req_q.row;
        end
        ST_CAS0: begin
          cmd_valid = 1'b1;
          cmd_code  = wr ? CMD_WR0 : CMD_RD0;
          cmd_col   = req_q.col;
          cas_load  = 1'b1;
          cas_val   = wr ? WRR_LD : RTP_LD;
        end
        ST_CAS1: begin
          cmd_valid = 1'b1;
          cmd_code  = wr ? CMD_WR1 : CMD_RD1;
          cmd_col   = req_q.col;
        end
        ST_PRE: begin
          cmd_valid = 1'b1;
          cmd_code  = CMD_PRE;
          cas_load  = 1'b1;
          cas_val   = RP_LD;
        end
        default: ;
      endcase
    end
    if (cmd_valid) begin
      cmd_bg = req_q.bg;
      cmd_ba = req_q.ba;
    end
  end

  ddr5_timing_cnt #(.CNT_W(CNT_W)) u_ras_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ras_load),
    .load_val (RAS_LD),
    .tick     (tick),
    .zero     (ras_zero)
  );

  ddr5_timing_cnt #(.CNT_W(CNT_W)) u_cas_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cas_load),
    .load_val (cas_val),
    .tick     (tick),
    .zero     (cas_zero)
  );

endmodule

`default_nettype wire

// File: tb/tb_ddr5_cmd_sequencer.sv
// ============================================================================
// tb_ddr5_cmd_sequencer : scoreboard bench for the DDR5 command sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ddr5_cmd_sequencer;

  localparam int T_RCD   = 39;
  localparam int T_RAS   = 76;
  localparam int T_RTP   = 18;
  localparam int T_CWL   = 38;
  localparam int T_BURST = 8;
  localparam int T_WR    = 48;
  localparam int T_RP    = 39;

  localparam logic [2:0] C_ACT0 = 3'd1;
  localparam logic [2:0] C_ACT1 = 3'd2;
  localparam logic [2:0] C_RD0  = 3'd3;
  localparam logic [2:0] C_RD1  = 3'd4;
  localparam logic [2:0] C_WR0  = 3'd5;
  localparam logic [2:0] C_WR1  = 3'd6;
  localparam logic [2:0] C_PRE  = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_opn = '0;
  logic [2:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        req_err;

  typedef struct {
    logic [2:0]  code;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
    int          at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  ddr5_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opn   (req_opn),
    .req_bg    (req_bg),
    .req_ba    (req_ba),
    .req_row   (req_row),
    .req_col   (req_col),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_bg    (cmd_bg),
    .cmd_ba    (cmd_ba),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .req_err   (req_err)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle whose closing edge samples rst low.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboard monitor: every issued command must match the queue head.
  task automatic monitor();
    exp_t e;
    checks++;
    if (cmd_valid === 1'b1) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: cycle %0d code %0d, required no command", cyc, cmd_code);
      end else begin
        e = q.pop_front();
        if (cmd_code !== e.code || cmd_bg !== e.bg || cmd_ba !== e.ba ||
            cmd_row !== e.row || cmd_col !== e.col || cyc != e.at) begin
          errors++;
          $display("FAIL cmd: got code=%0d bg=%0d ba=%0d row=%h col=%h @%0d, required code=%0d bg=%0d ba=%0d row=%h col=%h @%0d",
                   cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col, cyc,
                   e.code, e.bg, e.ba, e.row, e.col, e.at);
        end
      end
    end else if (cmd_valid !== 1'b0 || {cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col} !== 34'd0) begin
      errors++;
      $display("FAIL idle_fields: cycle %0d valid=%b code=%0d bg=%0d ba=%0d row=%h col=%h, required all 0",
               cyc, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain_to(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      step();
      n++;
    end
  endtask

  // Expected command stream for a request accepted at cycle t0.
  task automatic push_seq(input logic [1:0] opn, input logic [2:0] bg, input logic [1:0] ba,
                          input logic [15:0] row, input logic [9:0] col, input int t0,
                          output int rdy, output int pre);
    int act0, cas0, by_ras, by_cas;
    bit wr;
    wr     = (opn == 2'd1);
    act0   = (t0 % 2 == 0) ? t0 + 2 : t0 + 1;
    cas0   = act0 + 2 * T_RCD;
    by_ras = act0 + 2 * T_RAS;
    by_cas = cas0 + 2 * (wr ? (T_CWL + T_BURST + T_WR) : T_RTP);
    pre    = (by_ras > by_cas) ? by_ras : by_cas;
    rdy    = pre + 2 * T_RP;
    q.push_back('{C_ACT0, bg, ba, row, 10'd0, act0});
    q.push_back('{C_ACT1, bg, ba, row, 10'd0, act0 + 2});
    q.push_back('{wr ? C_WR0 : C_RD0, bg, ba, 16'd0, col, cas0});
    q.push_back('{wr ? C_WR1 : C_RD1, bg, ba, 16'd0, col, cas0 + 2});
    q.push_back('{C_PRE, bg, ba, 16'd0, 10'd0, pre});
  endtask

  task automatic do_req(input logic [1:0] opn, input logic [2:0] bg, input logic [1:0] ba,
                        input logic [15:0] row, input logic [9:0] col, input bit keep,
                        output int rdy, output int pre);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_at_issue: cycle %0d got %b, required 1", cyc, req_ready);
    end
    req_valid = 1'b1;
    req_opn = opn; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    rdy = cyc; pre = cyc;
    if (opn != 2'd3) push_seq(opn, bg, ba, row, col, cyc, rdy, pre);
    step();
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic finish_seq(input string name, input int rdy);
    drain_to(rdy - 1);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_early: cycle %0d got %b, required 0", name, cyc, req_ready);
    end
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_rise: cycle %0d got %b, required 1", name, cyc, req_ready);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_cmds: %0d commands not seen, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = 1'b0;
    q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (req_ready !== 1'b1 || req_err !== 1'b0 || cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b err=%b valid=%b code=%0d, required 1 0 0 0",
               req_ready, req_err, cmd_valid, cmd_code);
    end
  endtask

  task automatic test_read();
    int rdy, pre;
    reset_dut();
    do_req(2'd0, 3'd3, 2'd1, 16'h1A2B, 10'h155, 1'b0, rdy, pre);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_busy: cycle %0d ready %b, required 0", cyc, req_ready);
    end
    finish_seq("read", rdy);
  endtask

  task automatic test_write();
    int rdy, pre;
    reset_dut();
    do_req(2'd1, 3'd3, 2'd1, 16'h1A2B, 10'h155, 1'b0, rdy, pre);
    finish_seq("write", rdy);
  endtask

  task automatic test_ifetch();
    int rdy, pre;
    reset_dut();
    do_req(2'd2, 3'd7, 2'd3, 16'hFFFF, 10'h3FF, 1'b0, rdy, pre);
    finish_seq("ifetch", rdy);
  endtask

  task automatic test_illegal();
    int rdy, pre;
    reset_dut();
    do_req(2'd3, 3'd2, 2'd2, 16'h5555, 10'h0AA, 1'b0, rdy, pre);
    checks++;
    if (req_err !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err_pulse: cycle %0d err=%b ready=%b, required 1 1", cyc, req_err, req_ready);
    end
    step();
    checks++;
    if (req_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err_clear: cycle %0d err=%b ready=%b, required 0 1", cyc, req_err, req_ready);
    end
    do_req(2'd0, 3'd1, 2'd0, 16'h0001, 10'h001, 1'b0, rdy, pre);
    finish_seq("after_illegal", rdy);
  endtask

  task automatic test_back_to_back();
    int rdy_a, pre_a, rdy_b, pre_b;
    reset_dut();
    do_req(2'd0, 3'd4, 2'd2, 16'h1234, 10'h0F0, 1'b1, rdy_a, pre_a);
    req_opn = 2'd1; req_bg = 3'd6; req_ba = 2'd1; req_row = 16'hBEEF; req_col = 10'h2AA;
    push_seq(2'd1, 3'd6, 2'd1, 16'hBEEF, 10'h2AA, rdy_a, rdy_b, pre_b);
    drain_to(rdy_a - 1);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_early: cycle %0d got %b, required 0", cyc, req_ready);
    end
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_rise: cycle %0d got %b, required 1", cyc, req_ready);
    end
    step();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: cycle %0d ready %b, required 0", cyc, req_ready);
    end
    drain_to(pre_b);
    req_valid = 1'b0;
    finish_seq("b2b", rdy_b);
  endtask

  task automatic test_reset_midop();
    int rdy, pre;
    reset_dut();
    do_req(2'd0, 3'd5, 2'd3, 16'hCAFE, 10'h123, 1'b0, rdy, pre);
    drain_to(100);
    checks++;
    if (q.size() != 1) begin
      errors++;
      $display("FAIL midop_pending: %0d commands pending at cycle 100, required 1 (PRE)", q.size());
    end
    q.delete();
    rst = 1'b1;
    step();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || cmd_row !== 16'd0 || cmd_col !== 10'd0 ||
        req_ready !== 1'b1 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_state: valid=%b code=%0d row=%h col=%h ready=%b err=%b, required 0 0 0 0 1 0",
               cmd_valid, cmd_code, cmd_row, cmd_col, req_ready, req_err);
    end
    step();
    rst = 1'b0;
    do_req(2'd0, 3'd0, 2'd0, 16'h0F0F, 10'h100, 1'b0, rdy, pre);
    finish_seq("post_reset", rdy);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ifetch();
    test_illegal();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
